// File: rtl/me_dmt_pkg.sv
// Shared types and default geometry for the ME_DMT reference-row schedulers.
// The three sub-areas tile one search window: rows [0, SA2_BASE), [SA2_BASE, SA3_BASE), [SA3_BASE, LAST_ROW].
package me_dmt_pkg;

   localparam int unsigned DEF_ROW_W    = 7;
   localparam int unsigned DEF_SEL_W    = 4;
   localparam int unsigned DEF_SA2_BASE = 10;
   localparam int unsigned DEF_SA3_BASE = 36;
   localparam int unsigned DEF_LAST_ROW = 63;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } sched_state_e;

   localparam logic [1:0] SA_NONE = 2'd0;
   localparam logic [1:0] SA_1    = 2'd1;
   localparam logic [1:0] SA_2    = 2'd2;
   localparam logic [1:0] SA_3    = 2'd3;

endpackage

// File: rtl/me_row_sched_if.sv
// Control and bank-read signals of the row scheduler.
// The master side is the scheduler; the slave side is the ME top controller plus bank read port.
interface me_row_sched_if #(
   parameter int unsigned ROW_W = me_dmt_pkg::DEF_ROW_W,
   parameter int unsigned SEL_W = me_dmt_pkg::DEF_SEL_W
);
   logic             start;
   logic             abort;
   logic             rd_ready;
   logic             rd_valid;
   logic [ROW_W-1:0] row_count;
   logic [1:0]       sub_area;
   logic             sa_first;
   logic [SEL_W-1:0] rdR_sel;
   logic             busy;
   logic             done;

   modport master (
      input  start, abort, rd_ready,
      output rd_valid, row_count, sub_area, sa_first, rdR_sel, busy, done
   );

   modport slave (
      output start, abort, rd_ready,
      input  rd_valid, row_count, sub_area, sa_first, rdR_sel, busy, done
   );
endinterface

// File: rtl/me_row_bank_map.sv
// Combinational row -> sub-area / bank-select decode, shared by the read and write schedulers.
// The offset from the sub-area base is taken at full row width so a base above 15 is never aliased.
module me_row_bank_map
   import me_dmt_pkg::*;
#(
   parameter int unsigned ROW_W    = DEF_ROW_W,
   parameter int unsigned SEL_W    = DEF_SEL_W,
   parameter int unsigned SA2_BASE = DEF_SA2_BASE,
   parameter int unsigned SA3_BASE = DEF_SA3_BASE
) (
   input  logic [ROW_W-1:0] row,
   output logic [1:0]       sub_area,
   output logic [ROW_W-1:0] base,
   output logic [SEL_W-1:0] rdR_sel_next,
   output logic             sa_first
);

   logic [ROW_W-1:0] offset;

   always_comb begin
      sub_area = SA_3;
      base     = ROW_W'(SA3_BASE);
      if (row < ROW_W'(SA2_BASE)) begin
         sub_area = SA_1;
         base     = '0;
      end else if (row < ROW_W'(SA3_BASE)) begin
         sub_area = SA_2;
         base     = ROW_W'(SA2_BASE);
      end
      offset       = row - base;
      rdR_sel_next = offset[SEL_W-1:0];
      sa_first     = (row == base);
   end

endmodule

// File: rtl/me_row_sched.sv
// Reference-row read scheduler for one motion-estimation search window.
// All outputs are registered; the bank map is evaluated on the next row so select and row move together.
module me_row_sched
   import me_dmt_pkg::*;
#(
   parameter int unsigned ROW_W    = DEF_ROW_W,
   parameter int unsigned SEL_W    = DEF_SEL_W,
   parameter int unsigned SA2_BASE = DEF_SA2_BASE,
   parameter int unsigned SA3_BASE = DEF_SA3_BASE,
   parameter int unsigned LAST_ROW = DEF_LAST_ROW
) (
   input  logic           clk,
   input  logic           rst,
   me_row_sched_if.master bus
);

   sched_state_e     state_q, state_d;
   logic [ROW_W-1:0] row_count_q, row_count_d;
   logic [1:0]       sub_area_q, sub_area_d;
   logic [SEL_W-1:0] rdR_sel_q, rdR_sel_d;
   logic             sa_first_q, sa_first_d;
   logic             rd_valid_q, rd_valid_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [ROW_W-1:0] row_nxt;
   logic             scan_nxt;
   logic [1:0]       map_sub_area;
   logic [ROW_W-1:0] unused_map_base;
   logic [SEL_W-1:0] map_sel;
   logic             map_first;

   me_row_bank_map #(
      .ROW_W    (ROW_W),
      .SEL_W    (SEL_W),
      .SA2_BASE (SA2_BASE),
      .SA3_BASE (SA3_BASE)
   ) u_map (
      .row          (row_nxt),
      .sub_area     (map_sub_area),
      .base         (unused_map_base),
      .rdR_sel_next (map_sel),
      .sa_first     (map_first)
   );

   // abort outranks start, accept and the DONE->IDLE return.
   always_comb begin
      state_d = state_q;
      row_nxt = row_count_q;
      unique case (state_q)
         IDLE: begin
            if (!bus.abort && bus.start) begin
               state_d = SCAN;
               row_nxt = '0;
            end
         end
         SCAN: begin
            if (bus.abort) begin
               state_d = IDLE;
            end else if (bus.rd_ready) begin
               if (row_count_q == ROW_W'(LAST_ROW)) state_d = DONE;
               else                                 row_nxt = row_count_q + ROW_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      scan_nxt    = (state_d == SCAN);
      rd_valid_d  = scan_nxt;
      busy_d      = scan_nxt;
      done_d      = (state_d == DONE);
      row_count_d = scan_nxt ? row_nxt : '0;
      sub_area_d  = scan_nxt ? map_sub_area : SA_NONE;
      rdR_sel_d   = scan_nxt ? map_sel : '0;
      sa_first_d  = scan_nxt && map_first;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         row_count_q <= '0;
         sub_area_q  <= SA_NONE;
         rdR_sel_q   <= '0;
         sa_first_q  <= 1'b0;
         rd_valid_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         row_count_q <= row_count_d;
         sub_area_q  <= sub_area_d;
         rdR_sel_q   <= rdR_sel_d;
         sa_first_q  <= sa_first_d;
         rd_valid_q  <= rd_valid_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign bus.rd_valid  = rd_valid_q;
   assign bus.row_count = row_count_q;
   assign bus.sub_area  = sub_area_q;
   assign bus.sa_first  = sa_first_q;
   assign bus.rdR_sel   = rdR_sel_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_me_row_sched.sv
// Scoreboard bench for me_row_sched: expected beats are queued at start and popped per accepted row.
module tb_me_row_sched;
   import me_dmt_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   me_row_sched_if ifc ();

   me_row_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   typedef struct packed {
      logic [6:0] row;
      logic [3:0] sel;
      logic [1:0] sa;
      logic       first;
   } beat_t;

   int    checks   = 0;
   int    failures = 0;
   beat_t sb_q[$];

   function automatic beat_t model(input int r);
      beat_t b;
      int    base;
      base    = (r < 10) ? 0 : (r < 36) ? 10 : 36;
      b.row   = 7'(r);
      b.sel   = 4'((r - base) % 16);
      b.sa    = (r < 10) ? 2'd1 : (r < 36) ? 2'd2 : 2'd3;
      b.first = (r == base);
      return b;
   endfunction

   function automatic beat_t observed();
      beat_t b;
      b.row   = ifc.row_count;
      b.sel   = ifc.rdR_sel;
      b.sa    = ifc.sub_area;
      b.first = ifc.sa_first;
      return b;
   endfunction

   task automatic push_rows(input int n);
      sb_q.delete();
      for (int i = 0; i < n; i++) sb_q.push_back(model(i));
   endtask

   // Called at a falling edge; returns at the falling edge where row 0 is presented.
   task automatic do_start();
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst = 1'b1;
      #2;
      checks++; if (ifc.rd_valid !== 1'b0)  begin failures++; $display("FAIL reset_rd_valid got %0h want 0", ifc.rd_valid); end
      checks++; if (ifc.row_count !== 7'd0) begin failures++; $display("FAIL reset_row_count got %0h want 0", ifc.row_count); end
      checks++; if (ifc.sub_area !== 2'd0)  begin failures++; $display("FAIL reset_sub_area got %0h want 0", ifc.sub_area); end
      checks++; if (ifc.sa_first !== 1'b0)  begin failures++; $display("FAIL reset_sa_first got %0h want 0", ifc.sa_first); end
      checks++; if (ifc.rdR_sel !== 4'd0)   begin failures++; $display("FAIL reset_rdR_sel got %0h want 0", ifc.rdR_sel); end
      checks++; if (ifc.busy !== 1'b0)      begin failures++; $display("FAIL reset_busy got %0h want 0", ifc.busy); end
      checks++; if (ifc.done !== 1'b0)      begin failures++; $display("FAIL reset_done got %0h want 0", ifc.done); end
      @(negedge clk);
      rst = 1'b0;
      ifc.rd_ready = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (ifc.rd_valid !== 1'b0 || ifc.busy !== 1'b0)
         begin failures++; $display("FAIL idle_ready_no_effect got valid=%0h busy=%0h want 0 0", ifc.rd_valid, ifc.busy); end
   endtask

   task automatic test_full_scan();
      int    beats = 0, dones = 0, last_c = -1, done_c = -1;
      beat_t obs, exp_b;
      push_rows(64);
      ifc.rd_ready = 1'b1;
      do_start();
      for (int c = 0; c < 100; c++) begin
         obs = observed();
         if (ifc.rd_valid) begin
            beats++;
            last_c = c;
            checks++;
            if (sb_q.size() == 0) begin failures++; $display("FAIL full_extra_beat got %h want none", obs); end
            else begin
               exp_b = sb_q.pop_front();
               if (obs !== exp_b) begin failures++; $display("FAIL full_beat got %h want %h", obs, exp_b); end
            end
            if (obs.row == 7'd12) begin checks++; if (obs.sel !== 4'd2 || obs.sa !== 2'd2)
               begin failures++; $display("FAIL row12 got sel=%0d sa=%0d want 2 2", obs.sel, obs.sa); end end
            if (obs.row == 7'd18) begin checks++; if (obs.sel !== 4'd8)
               begin failures++; $display("FAIL row18 got sel=%0d want 8", obs.sel); end end
            if (obs.row == 7'd43) begin checks++; if (obs.sel !== 4'd7 || obs.sa !== 2'd3)
               begin failures++; $display("FAIL row43 got sel=%0d sa=%0d want 7 3", obs.sel, obs.sa); end end
         end
         if (ifc.done) begin dones++; done_c = c; end
         @(negedge clk);
      end
      checks++; if (beats !== 64) begin failures++; $display("FAIL full_beat_count got %0d want 64", beats); end
      checks++; if (dones !== 1)  begin failures++; $display("FAIL full_done_count got %0d want 1", dones); end
      checks++; if (done_c !== last_c + 1) begin failures++; $display("FAIL full_done_latency got %0d want %0d", done_c, last_c + 1); end
      checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL full_sb_left got %0d want 0", sb_q.size()); end
   endtask

   task automatic test_backpressure();
      int    stall = 0, dones = 0;
      beat_t obs, exp_b;
      push_rows(64);
      ifc.rd_ready = 1'b1;
      do_start();
      for (int c = 0; c < 120; c++) begin
         obs = observed();
         ifc.rd_ready = 1'b1;
         if (ifc.rd_valid && obs.row == 7'd35 && stall < 5) begin
            ifc.rd_ready = 1'b0;
            stall++;
            checks++;
            if (obs !== {7'd35, 4'd9, 2'd2, 1'b0}) begin failures++; $display("FAIL stall_frozen got %h want %h", obs, {7'd35, 4'd9, 2'd2, 1'b0}); end
         end
         if (ifc.rd_valid && ifc.rd_ready) begin
            checks++;
            if (sb_q.size() == 0) begin failures++; $display("FAIL bp_extra_beat got %h want none", obs); end
            else begin
               exp_b = sb_q.pop_front();
               if (obs !== exp_b) begin failures++; $display("FAIL bp_beat got %h want %h", obs, exp_b); end
            end
            if (obs.row == 7'd36) begin checks++; if (obs.sel !== 4'd0 || obs.first !== 1'b1)
               begin failures++; $display("FAIL row36_after_stall got sel=%0d first=%0d want 0 1", obs.sel, obs.first); end end
         end
         if (ifc.done) dones++;
         @(negedge clk);
      end
      ifc.rd_ready = 1'b1;
      checks++; if (stall !== 5) begin failures++; $display("FAIL bp_stall_cycles got %0d want 5", stall); end
      checks++; if (dones !== 1) begin failures++; $display("FAIL bp_done_count got %0d want 1", dones); end
      checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL bp_sb_left got %0d want 0", sb_q.size()); end
   endtask

   task automatic test_start_ignored();
      int    dones = 0;
      bit    pulsed = 0;
      beat_t obs, exp_b;
      push_rows(64);
      ifc.rd_ready = 1'b1;
      do_start();
      for (int c = 0; c < 100; c++) begin
         obs = observed();
         ifc.start = 1'b0;
         if (ifc.rd_valid && obs.row == 7'd20 && !pulsed) begin ifc.start = 1'b1; pulsed = 1; end
         if (ifc.rd_valid) begin
            checks++;
            if (sb_q.size() == 0) begin failures++; $display("FAIL si_extra_beat got %h want none", obs); end
            else begin
               exp_b = sb_q.pop_front();
               if (obs !== exp_b) begin failures++; $display("FAIL si_beat got %h want %h", obs, exp_b); end
            end
         end
         if (ifc.done) dones++;
         @(negedge clk);
      end
      ifc.start = 1'b0;
      checks++; if (dones !== 1) begin failures++; $display("FAIL si_done_count got %0d want 1", dones); end
      checks++; if (ifc.busy !== 1'b0 || ifc.rd_valid !== 1'b0)
         begin failures++; $display("FAIL si_idle_after got busy=%0h valid=%0h want 0 0", ifc.busy, ifc.rd_valid); end
      do_start();
      checks++; if (observed() !== model(0) || ifc.rd_valid !== 1'b1)
         begin failures++; $display("FAIL restart_row0 got %h valid=%0h want %h valid=1", observed(), ifc.rd_valid, model(0)); end
      ifc.abort = 1'b1;
      @(negedge clk);
      ifc.abort = 1'b0;
   endtask

   task automatic test_abort();
      int    dones = 0, ab_c = -1, valids = 0;
      bit    seen = 0;
      beat_t obs, exp_b;
      push_rows(41);
      ifc.rd_ready = 1'b1;
      do_start();
      for (int c = 0; c < 80; c++) begin
         obs = observed();
         ifc.abort = 1'b0;
         if (seen && c == ab_c + 1) begin
            checks++;
            if (ifc.rd_valid !== 1'b0 || ifc.busy !== 1'b0 || ifc.sub_area !== 2'd0)
               begin failures++; $display("FAIL abort_idle got valid=%0h busy=%0h sa=%0h want 0 0 0", ifc.rd_valid, ifc.busy, ifc.sub_area); end
         end
         if (ifc.rd_valid) begin
            checks++;
            if (sb_q.size() == 0) begin failures++; $display("FAIL abort_extra_beat got %h want none", obs); end
            else begin
               exp_b = sb_q.pop_front();
               if (obs !== exp_b) begin failures++; $display("FAIL abort_beat got %h want %h", obs, exp_b); end
            end
            if (obs.row == 7'd40 && !seen) begin ifc.abort = 1'b1; seen = 1; ab_c = c; end
         end
         if (ifc.done) dones++;
         @(negedge clk);
      end
      ifc.abort = 1'b0;
      checks++; if (!seen) begin failures++; $display("FAIL abort_row40_reached got 0 want 1"); end
      checks++; if (dones !== 0) begin failures++; $display("FAIL abort_no_done got %0d want 0", dones); end
      checks++; if (sb_q.size() !== 0) begin failures++; $display("FAIL abort_sb_left got %0d want 0", sb_q.size()); end
      ifc.start = 1'b1;
      ifc.abort = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      ifc.abort = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (ifc.rd_valid || ifc.busy) valids++;
         @(negedge clk);
      end
      checks++; if (valids !== 0) begin failures++; $display("FAIL abort_start_stays_idle got %0d active cycles want 0", valids); end
   endtask

   task automatic test_async_reset();
      bit    reached = 0;
      int    dones = 0;
      beat_t obs, exp_b;
      push_rows(51);
      ifc.rd_ready = 1'b1;
      do_start();
      for (int c = 0; c < 80; c++) begin
         obs = observed();
         if (ifc.rd_valid) begin
            checks++;
            if (sb_q.size() == 0) begin failures++; $display("FAIL ar_extra_beat got %h want none", obs); end
            else begin
               exp_b = sb_q.pop_front();
               if (obs !== exp_b) begin failures++; $display("FAIL ar_beat got %h want %h", obs, exp_b); end
            end
            if (obs.row == 7'd50) begin reached = 1; break; end
         end
         @(negedge clk);
      end
      checks++; if (!reached) begin failures++; $display("FAIL ar_row50_reached got 0 want 1"); end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({ifc.rd_valid, ifc.row_count, ifc.sub_area, ifc.sa_first, ifc.rdR_sel, ifc.busy, ifc.done} !== 17'd0)
         begin failures++; $display("FAIL ar_immediate got %h want 0", {ifc.rd_valid, ifc.row_count, ifc.sub_area, ifc.sa_first, ifc.rdR_sel, ifc.busy, ifc.done}); end
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (ifc.done) dones++;
         @(negedge clk);
      end
      checks++; if (dones !== 0) begin failures++; $display("FAIL ar_no_done got %0d want 0", dones); end
      do_start();
      checks++; if (observed() !== model(0) || ifc.rd_valid !== 1'b1)
         begin failures++; $display("FAIL ar_restart_row0 got %h valid=%0h want %h valid=1", observed(), ifc.rd_valid, model(0)); end
      @(negedge clk);
      checks++; if (observed() !== model(1)) begin failures++; $display("FAIL ar_restart_row1 got %h want %h", observed(), model(1)); end
      ifc.abort = 1'b1;
      @(negedge clk);
      ifc.abort = 1'b0;
   endtask

   initial begin
      ifc.start    = 1'b0;
      ifc.abort    = 1'b0;
      ifc.rd_ready = 1'b0;
      test_reset();
      test_full_scan();
      test_backpressure();
      test_start_ignored();
      test_abort();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
